// File: rtl/q_pkg.sv
// Shared types for the Q-learning datapath (action select and Q-update stages).
package q_pkg;

  localparam int unsigned N_ACTIONS = 4;
  localparam int unsigned Q_W       = 32;
  localparam int unsigned Q_FRAC    = 16;

  // Q values are two's-complement with Q_FRAC fractional bits.
  typedef logic signed [Q_W-1:0] q_t;
  typedef logic [3:0]            action_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sel_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; steps once per cycle while en is high.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  // Shift register; SEED must be non-zero or the sequence locks up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/q_action_select.sv
// Reads the four Q entries of one maze state, keeps the signed max (ties keep the lowest
// action) and picks the action to take, epsilon-greedy from an internal LFSR.
// Q width comes from the shared q_pkg so both pipeline stages agree.
module q_action_select
  import q_pkg::*;
#(
  parameter int unsigned N_STATES   = 37,
  parameter logic [7:0]  EPS_THRESH = 8'd26,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] state_i,
  output logic [5:0] rd_state,
  output action_t    rd_action,
  output logic       rd_en,
  input  q_t         rd_data,
  output q_t         max_Q,
  output action_t    best_action,
  output action_t    act_o,
  output logic       explore_o,
  output logic       err_o,
  output logic       done_o
);

  localparam logic [6:0] NStates = 7'(N_STATES);
  localparam action_t    LastAct = action_t'(N_ACTIONS - 1);

  sel_state_t state_q, state_d;

  logic        state_ok;
  logic        accept;
  logic        reject;
  logic        rd_vld_q;
  action_t     rd_act_q;
  q_t          run_max_q;
  action_t     run_best_q;
  logic [15:0] lfsr_q;
  logic        explore;
  logic        unused_lfsr;

  assign state_ok    = {1'b0, state_i} < NStates;
  assign explore     = lfsr_q[7:0] < EPS_THRESH;
  assign unused_lfsr = ^lfsr_q[15:10];

  // Advances only on an accepted valid start, so each scan sees a fresh value.
  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .en (accept),
    .q  (lfsr_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and start decode; start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (state_ok) begin
            accept  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (rd_action == LastAct) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read address generation: actions 0..N_ACTIONS-1 on consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state  <= '0;
      rd_action <= '0;
      rd_en     <= 1'b0;
    end else if (accept) begin
      rd_state  <= state_i;
      rd_action <= '0;
      rd_en     <= 1'b1;
    end else if (state_q == S_ISSUE) begin
      if (rd_action == LastAct) begin
        rd_en <= 1'b0;
      end else begin
        rd_action <= rd_action + action_t'(1);
      end
    end
  end

  // Running max; rd_data belongs to the address presented one cycle earlier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q   <= 1'b0;
      rd_act_q   <= '0;
      run_max_q  <= '0;
      run_best_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      rd_act_q <= rd_action;
      // Strictly greater keeps the lowest index on ties.
      if (rd_vld_q && ((rd_act_q == '0) || (rd_data > run_max_q))) begin
        run_max_q  <= rd_data;
        run_best_q <= rd_act_q;
      end
    end
  end

  // Result registers; held unchanged while done_o is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_Q       <= '0;
      best_action <= '0;
      act_o       <= '0;
      explore_o   <= 1'b0;
      err_o       <= 1'b0;
      done_o      <= 1'b0;
    end else if (reject) begin
      max_Q       <= '0;
      best_action <= '0;
      act_o       <= '0;
      explore_o   <= 1'b0;
      err_o       <= 1'b1;
      done_o      <= 1'b1;
    end else if (accept) begin
      err_o  <= 1'b0;
      done_o <= 1'b0;
    end else if (state_q == S_DONE) begin
      max_Q       <= run_max_q;
      best_action <= run_best_q;
      explore_o   <= explore;
      act_o       <= explore ? action_t'({2'b00, lfsr_q[9:8]}) : run_best_q;
      done_o      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_q_action_select.sv
// Directed bench: one greedy-only instance (EPS 0) and one always-explore instance (EPS FF)
// share stimulus; each has its own 1-cycle-latency Q-table read model.
module tb_q_action_select;
  import q_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] state_i;

  logic [5:0] rd_state, x_rd_state;
  action_t    rd_action, x_rd_action;
  logic       rd_en, x_rd_en;
  q_t         rd_data, x_rd_data;
  q_t         max_Q, x_max_Q;
  action_t    best_action, x_best_action;
  action_t    act_o, x_act_o;
  logic       explore_o, x_explore_o;
  logic       err_o, x_err_o;
  logic       done_o, x_done_o;

  q_t mem [64][4];

  int n_pass  = 0;
  int n_total = 0;
  int rd_cnt  = 0;
  int rd_cnt36 = 0;

  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  q_action_select #(
    .N_STATES(37), .EPS_THRESH(8'd0), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .state_i(state_i),
    .rd_state(rd_state), .rd_action(rd_action), .rd_en(rd_en), .rd_data(rd_data),
    .max_Q(max_Q), .best_action(best_action), .act_o(act_o), .explore_o(explore_o),
    .err_o(err_o), .done_o(done_o)
  );

  q_action_select #(
    .N_STATES(37), .EPS_THRESH(8'hFF), .LFSR_SEED(SEED)
  ) dut_x (
    .clk(clk), .rst(rst), .start(start), .state_i(state_i),
    .rd_state(x_rd_state), .rd_action(x_rd_action), .rd_en(x_rd_en), .rd_data(x_rd_data),
    .max_Q(x_max_Q), .best_action(x_best_action), .act_o(x_act_o), .explore_o(x_explore_o),
    .err_o(x_err_o), .done_o(x_done_o)
  );

  // Q-table read ports and read-strobe monitor.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_state][rd_action[1:0]];
      rd_cnt  <= rd_cnt + 1;
      if (rd_state == 6'd36) rd_cnt36 <= rd_cnt36 + 1;
    end
    if (x_rd_en) x_rd_data <= mem[x_rd_state][x_rd_action[1:0]];
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One valid scan; optionally pulses a stray start during ISSUE.
  task automatic run(input logic [5:0] s, input logic [31:0] emax, input logic [3:0] ebest,
                     input bit inject, input string tag);
    int cyc;
    logic [3:0] x_act;
    logic x_expl;
    @(negedge clk); start = 1'b1; state_i = s;
    @(negedge clk); start = 1'b0;
    lfsr_m = lfsr_next(lfsr_m);
    chk({tag, "_busy"}, {31'd0, done_o}, 32'd0);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 20) begin
      if (inject) begin
        start   = (cyc == 1);
        state_i = 6'd7;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, 32'd6);
    chk({tag, "_max"}, max_Q, emax);
    chk({tag, "_best"}, {28'd0, best_action}, {28'd0, ebest});
    chk({tag, "_act"}, {28'd0, act_o}, {28'd0, ebest});
    chk({tag, "_expl"}, {31'd0, explore_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
    x_expl = lfsr_m[7:0] < 8'hFF;
    x_act  = x_expl ? {2'b00, lfsr_m[9:8]} : ebest;
    chk({tag, "_x_max"}, x_max_Q, emax);
    chk({tag, "_x_act"}, {28'd0, x_act_o}, {28'd0, x_act});
    chk({tag, "_x_expl"}, {31'd0, x_explore_o}, {31'd0, x_expl});
  endtask

  initial begin
    int c0, c36;
    rst = 1'b1; start = 1'b0; state_i = '0;
    for (int s = 0; s < 64; s++) for (int a = 0; a < 4; a++) mem[s][a] = '0;
    mem[3] = '{32'h0001_0000, 32'h0003_8000, 32'hFFFE_0000, 32'h0000_4000};
    mem[7] = '{32'hFFFF_0000, 32'hFFFF_8000, 32'hFFFD_0000, 32'hFFFF_8000};
    mem[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_2000};
    lfsr_m = SEED;
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_rd_addr", {22'd0, rd_state, rd_action}, 32'd0);
    chk("rst_max", max_Q, 32'd0);
    chk("rst_outs", {24'd0, best_action, act_o}, 32'd0);
    chk("rst_flags", {30'd0, explore_o, err_o}, 32'd0);
    rst = 1'b1;

    // Greedy max, ties and an all-zero row at the top state index.
    run(6'd3, 32'h0003_8000, 4'd1, 1'b0, "row_mixed");
    repeat (3) @(negedge clk);
    chk("hold_done", {31'd0, done_o}, 32'd1);
    chk("hold_max", max_Q, 32'h0003_8000);
    run(6'd7, 32'hFFFF_8000, 4'd1, 1'b0, "row_neg_tie");
    c0 = rd_cnt; c36 = rd_cnt36;
    run(6'd36, 32'd0, 4'd0, 1'b0, "row_zero");
    chk("s36_reads", rd_cnt - c0, 32'd4);
    chk("s36_addr", rd_cnt36 - c36, 32'd4);

    // Out-of-range state: immediate error, no reads, no LFSR step.
    c0 = rd_cnt;
    @(negedge clk); start = 1'b1; state_i = 6'd37;
    @(negedge clk); start = 1'b0;
    chk("bad_done", {31'd0, done_o}, 32'd1);
    chk("bad_err", {31'd0, err_o}, 32'd1);
    chk("bad_max", max_Q, 32'd0);
    chk("bad_act", {28'd0, act_o}, 32'd0);
    repeat (8) @(negedge clk);
    chk("bad_noread", rd_cnt - c0, 32'd0);
    run(6'd5, 32'h0000_2000, 4'd3, 1'b0, "err_clear");

    // Remaining starts of eight since reset; exploration tracks the reference LFSR.
    run(6'd3, 32'h0003_8000, 4'd1, 1'b0, "expl5");
    run(6'd7, 32'hFFFF_8000, 4'd1, 1'b0, "expl6");
    run(6'd36, 32'd0, 4'd0, 1'b0, "expl7");
    run(6'd3, 32'h0003_8000, 4'd1, 1'b1, "stray_start");

    // Reset mid-scan, then restart from the seed.
    @(negedge clk); start = 1'b1; state_i = 6'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_rd", {21'd0, rd_en, rd_state, rd_action}, 32'd0);
    chk("abort_max", max_Q, 32'd0);
    chk("abort_outs", {22'd0, best_action, act_o, explore_o, err_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    lfsr_m = SEED;
    run(6'd7, 32'hFFFF_8000, 4'd1, 1'b0, "restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
